// File: rtl/bpsk_modem_pkg.sv
// Shared definitions for the BPSK modem receive/transmit paths.
package bpsk_modem_pkg;

  localparam logic [7:0] ETHERNET_SFD = 8'hD5;
  localparam int         LEN_W        = 8;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD
  } deframer_state_t;

endpackage

// File: rtl/sfd_detector.sv
// Serial start-of-frame delimiter detector; bits arrive MSB first.
module sfd_detector
  import bpsk_modem_pkg::*;
#(
  parameter int               SFD_W = 8,
  parameter logic [SFD_W-1:0] SFD   = SFD_W'(ETHERNET_SFD)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_en,
  input  logic bit_in,
  output logic match
);

  logic [SFD_W-1:0] sh_q, sh_d, shifted;
  logic [SFD_W:0]   sh_ext;

  // match is combinational on the post-shift value so the current bit counts
  always_comb begin
    sh_ext  = {sh_q, bit_in};
    shifted = sh_ext[SFD_W-1:0];
    sh_d    = sh_q;
    if (clear) begin
      sh_d = '0;
    end else if (bit_en) begin
      sh_d = shifted;
    end
    match = bit_en && !clear && (shifted == SFD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/axis_sfd_deframer.sv
// Bit-serial deframer: SFD hunt, 8-bit byte-length header, payload packed
// into AXI4-Stream beats behind a single-entry output register.
module axis_sfd_deframer
  import bpsk_modem_pkg::*;
#(
  parameter int               DATA_W = 32,
  parameter int               SFD_W  = 8,
  parameter logic [SFD_W-1:0] SFD    = SFD_W'(ETHERNET_SFD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_in_en,
  input  logic                data_in,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                frame_active,
  output logic                overflow
);

  localparam int KW  = DATA_W / 8;
  localparam int BCW = $clog2(DATA_W);

  deframer_state_t   state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] word_q, word_d, word_next;
  logic [KW-1:0]     keep_acc_q, keep_acc_d, keep_new;
  logic [KW:0]       keep_ext;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [KW-1:0]     tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic              frame_active_q, frame_active_d;
  logic              overflow_q, overflow_d;
  logic              byte_done, final_bit, beat_done;
  logic              det_clear, det_bit_en, sfd_match;

  assign det_clear  = (state_q != HUNT);
  assign det_bit_en = data_in_en && (state_q == HUNT);

  sfd_detector #(
    .SFD_W (SFD_W),
    .SFD   (SFD)
  ) u_sfd_detector (
    .clk    (clk),
    .rst    (rst),
    .clear  (det_clear),
    .bit_en (det_bit_en),
    .bit_in (data_in),
    .match  (sfd_match)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_d     = word_q;
    keep_acc_d = keep_acc_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    overflow_d = 1'b0;

    word_next            = word_q;
    word_next[bit_cnt_q] = data_in;
    keep_ext             = {keep_acc_q, 1'b1};
    keep_new             = keep_ext[KW-1:0];
    byte_done            = (bit_cnt_q[2:0] == 3'd7);
    final_bit            = byte_done && (byte_cnt_q == len_q - LEN_W'(1));
    beat_done            = (bit_cnt_q == BCW'(DATA_W - 1)) || final_bit;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      HUNT: begin
        if (sfd_match) state_d = LEN;
      end
      LEN: begin
        if (data_in_en) begin
          len_d     = {data_in, len_q[LEN_W-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (byte_done) begin
            bit_cnt_d = '0;
            state_d   = (len_d == '0) ? HUNT : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (data_in_en) begin
          word_d    = word_next;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (byte_done) begin
            byte_cnt_d = byte_cnt_q + LEN_W'(1);
            keep_acc_d = keep_new;
          end
          if (beat_done) begin
            word_d     = '0;
            bit_cnt_d  = '0;
            keep_acc_d = '0;
            // A slot is free if empty or draining this very cycle
            if (!tvalid_q || m_axis_tready) begin
              tdata_d  = word_next;
              tkeep_d  = keep_new;
              tlast_d  = final_bit;
              tvalid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
              state_d    = HUNT;
            end
            if (final_bit) state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (state_d == HUNT) begin
      len_d      = '0;
      byte_cnt_d = '0;
      bit_cnt_d  = '0;
      word_d     = '0;
      keep_acc_d = '0;
    end

    frame_active_d = (state_d != HUNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= HUNT;
      len_q          <= '0;
      byte_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      word_q         <= '0;
      keep_acc_q     <= '0;
      tdata_q        <= '0;
      tkeep_q        <= '0;
      tlast_q        <= 1'b0;
      tvalid_q       <= 1'b0;
      frame_active_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      byte_cnt_q     <= byte_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      word_q         <= word_d;
      keep_acc_q     <= keep_acc_d;
      tdata_q        <= tdata_d;
      tkeep_q        <= tkeep_d;
      tlast_q        <= tlast_d;
      tvalid_q       <= tvalid_d;
      frame_active_q <= frame_active_d;
      overflow_q     <= overflow_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_active  = frame_active_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_sfd_deframer.sv
// Directed bench for axis_sfd_deframer at DATA_W 32, 8 and 64 with a beat scoreboard.
module tb_axis_sfd_deframer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic din = 1'b0;
  logic en  = 1'b0;
  int   sel = 0;
  logic en32, en8, en64;
  assign en32 = en && (sel == 0);
  assign en8  = en && (sel == 1);
  assign en64 = en && (sel == 2);

  logic tready32 = 1'b1, tready8 = 1'b1, tready64 = 1'b1;

  logic [31:0] td32; logic [3:0] tk32; logic tl32, tv32, fa32_o, ov32_o;
  logic [7:0]  td8;  logic [0:0] tk8;  logic tl8,  tv8,  fa8_o,  ov8_o;
  logic [63:0] td64; logic [7:0] tk64; logic tl64, tv64, fa64_o, ov64_o;

  axis_sfd_deframer #(.DATA_W(32), .SFD_W(8), .SFD(8'hD5)) u32 (
    .clk(clk), .rst(rst), .data_in_en(en32), .data_in(din),
    .m_axis_tdata(td32), .m_axis_tkeep(tk32), .m_axis_tlast(tl32),
    .m_axis_tvalid(tv32), .m_axis_tready(tready32),
    .frame_active(fa32_o), .overflow(ov32_o));

  axis_sfd_deframer #(.DATA_W(8), .SFD_W(8), .SFD(8'hD5)) u8 (
    .clk(clk), .rst(rst), .data_in_en(en8), .data_in(din),
    .m_axis_tdata(td8), .m_axis_tkeep(tk8), .m_axis_tlast(tl8),
    .m_axis_tvalid(tv8), .m_axis_tready(tready8),
    .frame_active(fa8_o), .overflow(ov8_o));

  axis_sfd_deframer #(.DATA_W(64), .SFD_W(8), .SFD(8'hD5)) u64 (
    .clk(clk), .rst(rst), .data_in_en(en64), .data_in(din),
    .m_axis_tdata(td64), .m_axis_tkeep(tk64), .m_axis_tlast(tl64),
    .m_axis_tvalid(tv64), .m_axis_tready(tready64),
    .frame_active(fa64_o), .overflow(ov64_o));

  int compared   = 0;
  int mismatched = 0;
  beat_t q32[$], q8[$], q64[$];
  int ovf32 = 0, ovf8 = 0, ovf64 = 0;
  int fa32  = 0;
  logic [7:0] pl [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q32.size();
      1:       return q8.size();
      default: return q64.size();
    endcase
  endfunction

  task automatic check_beat(input int which, input beat_t obs);
    beat_t e;
    compared++;
    assert (qsize(which) > 0) else begin
      mismatched++;
      $error("FAIL beat_unexpected_w%0d observed=%0h expected=none", which, obs);
    end
    if (qsize(which) > 0) begin
      case (which)
        0:       e = q32.pop_front();
        1:       e = q8.pop_front();
        default: e = q64.pop_front();
      endcase
      chk($sformatf("beat_w%0d", which), 128'(obs), 128'(e));
    end
  endtask

  always @(negedge clk) begin
    beat_t o;
    if (!rst) begin
      if (tv32 && tready32) begin
        o.d = 64'(td32); o.k = 8'(tk32); o.l = tl32;
        check_beat(0, o);
      end
      if (tv8 && tready8) begin
        o.d = 64'(td8); o.k = 8'(tk8); o.l = tl8;
        check_beat(1, o);
      end
      if (tv64 && tready64) begin
        o.d = td64; o.k = tk64; o.l = tl64;
        check_beat(2, o);
      end
      if (ov32_o) ovf32++;
      if (ov8_o)  ovf8++;
      if (ov64_o) ovf64++;
      if (fa32_o) fa32++;
    end
  end

  // Bits are driven just after a rising edge; on return the consuming edge has just passed.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    din = b;
    en  = 1'b1;
    @(posedge clk); #1;
    en  = 1'b0;
  endtask

  task automatic send_byte_msb(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
  endtask

  task automatic send_byte_lsb(input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) send_bit(b[i], gap);
  endtask

  task automatic send_hdr(input logic [7:0] len, input int gap);
    send_byte_msb(8'hD5, gap);
    send_byte_lsb(len, gap);
  endtask

  task automatic push_model(input int which, input int len);
    int    kb;
    int    idx;
    beat_t b;
    kb  = (which == 0) ? 4 : (which == 1) ? 1 : 8;
    idx = 0;
    while (idx < len) begin
      b = '0;
      for (int k = 0; k < kb && idx < len; k++) begin
        b.d[8*k +: 8] = pl[idx];
        b.k[k]        = 1'b1;
        idx++;
      end
      b.l = (idx == len);
      case (which)
        0:       q32.push_back(b);
        1:       q8.push_back(b);
        default: q64.push_back(b);
      endcase
    end
  endtask

  task automatic send_frame(input int which, input int len, input int gap, input bit push);
    sel = which;
    if (push) push_model(which, len);
    send_hdr(8'(len), gap);
    for (int i = 0; i < len; i++) send_byte_lsb(pl[i], gap);
  endtask

  task automatic wait_drain(input int which, input string tag);
    for (int i = 0; i < 60 && qsize(which) != 0; i++) @(posedge clk);
    #1;
    chk(tag, 128'(qsize(which)), 128'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int ov_before;

    #1 rst = 1'b1;
    #2;
    chk("reset_w32", {td32, tk32, tl32, tv32, fa32_o, ov32_o}, '0);
    chk("reset_w8",  {td8,  tk8,  tl8,  tv8,  fa8_o,  ov8_o},  '0);
    chk("reset_w64", {td64, tk64, tl64, tv64, fa64_o, ov64_o}, '0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Nominal frame
    pl[0] = 8'h10; pl[1] = 8'h32; pl[2] = 8'h54; pl[3] = 8'h76; pl[4] = 8'h98;
    q32.push_back('{64'h76543210, 8'h0F, 1'b0});
    q32.push_back('{64'h00000098, 8'h01, 1'b1});
    send_frame(0, 5, 0, 1'b0);
    wait_drain(0, "nominal_drain");
    idle(3);
    chk("nominal_no_ovf", 128'(ovf32), 128'(0));

    // Decoy pattern then a real frame
    sel = 0;
    send_byte_msb(8'hD4, 0);
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3; pl[3] = 8'hD4;
    q32.push_back('{64'hD4C3B2A1, 8'h0F, 1'b1});
    send_frame(0, 4, 0, 1'b0);
    wait_drain(0, "decoy_drain");
    idle(10);

    // Empty frame
    fa32 = 0;
    send_hdr(8'd0, 0);
    idle(6);
    chk("empty_fa_cycles", 128'(fa32), 128'(8));
    chk("empty_no_valid", 128'(tv32), 128'(0));

    // Gapped enable, latency to tvalid
    pl[0] = 8'h10; pl[1] = 8'h32; pl[2] = 8'h54; pl[3] = 8'h76; pl[4] = 8'h98;
    q32.push_back('{64'h76543210, 8'h0F, 1'b0});
    q32.push_back('{64'h00000098, 8'h01, 1'b1});
    send_hdr(8'd5, 1);
    for (int i = 0; i < 3; i++) send_byte_lsb(pl[i], 1);
    for (int i = 0; i < 7; i++) send_bit(pl[3][i], 1);
    chk("gap_pre0", 128'(tv32), 128'(0));
    send_bit(pl[3][7], 1);
    chk("gap_lat0", 128'(tv32), 128'(1));
    chk("gap_data0", 128'(td32), 128'(32'h76543210));
    for (int i = 0; i < 7; i++) send_bit(pl[4][i], 1);
    chk("gap_pre1", 128'(tv32), 128'(0));
    send_bit(pl[4][7], 1);
    chk("gap_lat1", 128'(tv32), 128'(1));
    chk("gap_last1", 128'(tl32), 128'(1));
    wait_drain(0, "gap_drain");
    idle(3);

    // Backpressure overflow
    tready32 = 1'b0;
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    q32.push_back('{64'h04030201, 8'h0F, 1'b0});
    ov_before = ovf32;
    send_frame(0, 8, 0, 1'b0);
    idle(3);
    chk("bp_ovf_once", 128'(ovf32 - ov_before), 128'(1));
    chk("bp_hold_valid", 128'(tv32), 128'(1));
    chk("bp_hold_beat", 128'({td32, tk32, tl32}), 128'({32'h04030201, 4'hF, 1'b0}));
    chk("bp_hunt", 128'(fa32_o), 128'(0));
    tready32 = 1'b1;
    wait_drain(0, "bp_drain");
    idle(5);
    chk("bp_empty_after", 128'(tv32), 128'(0));

    // Width sweep
    for (int i = 0; i < 9; i++) pl[i] = 8'(8'h21 * (i + 1));
    send_frame(1, 9, 0, 1'b1);
    wait_drain(1, "w8_drain");
    send_frame(2, 9, 0, 1'b1);
    wait_drain(2, "w64_drain");
    idle(3);
    chk("w8_no_ovf", 128'(ovf8), 128'(0));
    chk("w64_no_ovf", 128'(ovf64), 128'(0));

    // Reset mid-payload with a beat pending
    sel = 0;
    tready32 = 1'b0;
    send_hdr(8'd8, 0);
    for (int i = 0; i < 5; i++) send_byte_lsb(8'h5A, 0);
    chk("rst_pre_valid", 128'(tv32), 128'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 128'({td32, tk32, tl32, tv32, fa32_o, ov32_o}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    tready32 = 1'b1;
    idle(2);
    pl[0] = 8'h10; pl[1] = 8'h32; pl[2] = 8'h54; pl[3] = 8'h76; pl[4] = 8'h98;
    send_frame(0, 5, 0, 1'b1);
    wait_drain(0, "post_rst_drain");
    idle(10);

    chk("final_q32", 128'(q32.size()), 128'(0));
    chk("final_q8",  128'(q8.size()),  128'(0));
    chk("final_q64", 128'(q64.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axis_sfd_deframer.md
# axis_sfd_deframer

Parametrised bit-serial-to-AXI4-Stream deframer on the demodulator side of the PL→PS path. It hunts for a configurable start-of-frame delimiter in the demodulated bit stream, reads an 8-bit byte-length header, and packs the payload into `DATA_W`-bit AXIS beats with correct `tkeep`/`tlast`. It supersedes the fixed one-word 32-bit capture: length, width and SFD are all configurable, the input carries a bit-enable, and backpressure is handled.

## Interface
- `DATA_W`, 32: AXIS data width in bits; multiple of 8, 8..64.
- `SFD_W`, 8: delimiter length in bits, 1..32.
- `SFD`, `ETHERNET_SFD` (8'hD5): delimiter value, transmitted MSB first.

- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in_en`  in  1  qualifies `data_in`; bits are consumed only when high.
- `data_in`  in  1  demodulated bit.
- `m_axis_tdata`  out  DATA_W  payload beat, byte 0 in bits [7:0].
- `m_axis_tkeep`  out  DATA_W/8  valid-byte mask, contiguous from LSB.
- `m_axis_tlast`  out  1  last beat of frame.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream accept.
- `frame_active`  out  1  high in LEN and PAYLOAD states.
- `overflow`  out  1  one-cycle pulse when a completed beat is dropped.

## Operation
- **Reset values:** every output is 0, the state is HUNT, and all shift registers and counters are 0.
- **HUNT:**
  - On each enabled bit, shift `data_in` into the LSB of an `SFD_W`-bit register.
  - The match is computed on the post-shift value, so the comparison includes the current bit.
  - On a match, go to LEN. The register clears on every entry to HUNT, so delimiter bits are never reused.
- **LEN:**
  - Collect 8 enabled bits, LSB first, into `len` (payload bytes).
  - If `len == 0`, return to HUNT with no output. Otherwise go to PAYLOAD.
- **PAYLOAD:**
  - Each enabled bit is written into word bit `bit_cnt`, LSB first, and a byte counter tracks bytes received.
  - A beat completes when `bit_cnt` reaches `DATA_W-1`, or when the final bit of byte `len-1` arrives.
  - On completion, load the output register:
    - `tdata` = assembled word, with unused upper bytes 0;
    - `tkeep` = one bit per received byte of this beat;
    - `tlast` = 1 only on the frame's final beat.
  - After the final beat, return to HUNT.
- **Output register:** single-entry. `tvalid` stays high and `tdata`/`tkeep`/`tlast` stay stable until `tvalid && tready`.
- **Load and drain in the same cycle:** if a beat completes in the same cycle the register drains, the new beat loads with no gap.
- **Overflow:**
  - If a beat completes while the register holds an unaccepted beat, the new beat is dropped and `overflow` pulses for one cycle.
  - The rest of the frame is discarded and the state goes to HUNT.
  - The pending beat is kept, including its `tlast` value.
- **`data_in_en` low:** all state holds in every state.
- **Reset mid-frame:** the partial frame is discarded and no beat is emitted.

## Timing
- **Latency:** `tvalid` rises on the cycle after the enabled cycle carrying a beat's last bit.
- **Throughput:** 1 bit per clock. With `DATA_W ≥ 8`, back-to-back beats are ≥8 cycles apart, so there is no overflow when `tready` is held high.
- **`frame_active`:** rises the cycle after the SFD match and falls the cycle after the final payload bit or an overflow.
- **Unit conventions:** `len` counts bytes. The maximum frame is 255 bytes, i.e. `ceil(255/(DATA_W/8))` beats. Counters are sized with `$clog2`.

## Structure
- **Shared package `bpsk_modem_pkg`:** holds `ETHERNET_SFD`, the `deframer_state_t` enum (HUNT, LEN, PAYLOAD) and `LEN_W = 8`.
- **Sub-module `sfd_detector`:** parametrised by `SFD_W`/`SFD`, with ports `clk`, `rst`, `clear`, `bit_en`, `bit_in` and a `match` pulse. It is reused by the TX loopback checker.
- **Top:** the FSM, word packer and output register live in the top module.

## Test plan
- **Nominal frame** (`DATA_W=32`, `tready=1`): SFD D5, len 5, bytes 10 32 54 76 98 → beat 0x76543210 with tkeep F, tlast 0; then beat 0x00000098 with tkeep 1, tlast 1; `overflow` stays 0.
- **Decoy and empty frame:**
  - Bits 1101_0100 followed by a true D5, len 4 → exactly one beat (tkeep F, tlast 1).
  - Len 0 → no beat, and `frame_active` is high for 8 enabled bits only.
- **Gapped enable:** same frame as the nominal case, with `data_in_en` toggling at 50% → identical beats, each `tvalid` one cycle after the last enabled bit.
- **Backpressure:**
  - `tready=0` through a len-8 frame → first beat holds stable, `overflow` pulses once at the second beat's completion, state returns to HUNT.
  - Raising `tready` then → only the first beat transfers.
- **Width sweep:** `DATA_W=8` and `DATA_W=64` with len 9 → 9 beats (all tkeep 1), and 2 beats (tkeep FF then 01) respectively, with tlast on the last beat.
- **Reset mid-PAYLOAD:** assert `rst` mid-payload → all outputs 0 immediately; a next clean frame decodes correctly.
